// File: rtl/id_redirect_unit_pkg.sv
// Shared decode constants, redirect encodings and state encoding for id_redirect_unit.
// Optional build macro: BRANCH_DELAY_SLOT_EN (see id_redirect_unit.sv).
package id_redirect_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    PCSRC_PC4 = 2'b00,
    PCSRC_BEQ = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_SQUASH = 2'd2
  } state_e;

  typedef struct packed {
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jr;
    logic       reads_rs;
    logic       reads_rt;
    logic [4:0] rs;
    logic [4:0] rt;
  } dec_t;

  // An invalid IF/ID slot decodes to nothing so it can neither stall nor redirect.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic valid);
    dec_t d;
    d.rs       = rs;
    d.rt       = rt;
    d.is_beq   = valid && (op == OP_BEQ);
    d.is_bne   = valid && (op == OP_BNE);
    d.is_j     = valid && (op == OP_J);
    d.is_jr    = valid && (op == OP_RTYPE) && (fn == FN_JR);
    d.reads_rs = valid && (op != OP_J) && (op != OP_JAL);
    d.reads_rt = valid && ((op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW));
    return d;
  endfunction

endpackage

// File: rtl/id_redirect_unit_if.sv
// Fetch <-> decode bus: fetched word/PC+4 into ID, redirect controls back to fetch.
interface id_redirect_unit_if;
  logic [31:0] pc_4_if;
  logic [31:0] instr_if;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic [31:0] beq;
  logic [31:0] jr;
  logic [27:0] offset28;
  logic [3:0]  pc_4_id;

  modport master (output pc_4_if, instr_if,
                  input  pc_write, pc_src, beq, jr, offset28, pc_4_id);
  modport slave  (input  pc_4_if, instr_if,
                  output pc_write, pc_src, beq, jr, offset28, pc_4_id);
endinterface

// File: rtl/id_redirect_unit_hazard_detect.sv
// Source/destination compare between the ID instruction and EX/MEM producers.
module hazard_detect (
  input  logic       is_br,
  input  logic       is_cmp,
  input  logic       reads_rs,
  input  logic       reads_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       id_ex_reg_write,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_dst,
  input  logic       ex_mem_mem_read,
  input  logic [4:0] ex_mem_dst,
  output logic       hazard
);
  logic ex_src_hit, ex_opnd_hit, mem_opnd_hit;

  // $0 is never a real destination, so a zero dst cannot match.
  always_comb begin
    ex_src_hit   = (id_ex_dst != 5'd0) &&
                   ((reads_rs && (rs == id_ex_dst)) || (reads_rt && (rt == id_ex_dst)));
    ex_opnd_hit  = (id_ex_dst != 5'd0) &&
                   ((rs == id_ex_dst) || (is_cmp && (rt == id_ex_dst)));
    mem_opnd_hit = (ex_mem_dst != 5'd0) &&
                   ((rs == ex_mem_dst) || (is_cmp && (rt == ex_mem_dst)));
    hazard = (id_ex_mem_read && ex_src_hit) ||
             (is_br && id_ex_reg_write && ex_opnd_hit) ||
             (is_br && ex_mem_mem_read && mem_opnd_hit);
  end
endmodule

// File: rtl/id_redirect_unit.sv
// IF/ID register, branch/jump resolution in ID and fetch redirect/stall control.
// Build macro BRANCH_DELAY_SLOT_EN: keep the slot after a taken redirect instead of squashing it.
module id_redirect_unit
  import id_redirect_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  id_redirect_unit_if.slave   fetch,
  input  logic [31:0]         rs_data,
  input  logic [31:0]         rt_data,
  input  logic                id_ex_reg_write,
  input  logic                id_ex_mem_read,
  input  logic [4:0]          id_ex_dst,
  input  logic                ex_mem_mem_read,
  input  logic [4:0]          ex_mem_dst,
  output logic [31:0]         instr_id,
  output logic [31:0]         pc_4_id_full,
  output logic                id_valid,
  output logic                bubble_ex
);
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit SQUASH_EN = 1'b0;
`else
  localparam bit SQUASH_EN = 1'b1;
`endif

  logic [31:0] instr_q, instr_d, pc_4_q, pc_4_d;
  logic        valid_q, valid_d;
  state_e      state_q, state_d;
  dec_t        dec;
  logic        hazard, ops_eq, taken;
  pc_src_e     pc_src;

  hazard_detect u_hazard (
    .is_br           (dec.is_beq | dec.is_bne | dec.is_jr),
    .is_cmp          (dec.is_beq | dec.is_bne),
    .reads_rs        (dec.reads_rs),
    .reads_rt        (dec.reads_rt),
    .rs              (dec.rs),
    .rt              (dec.rt),
    .id_ex_reg_write (id_ex_reg_write),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_dst       (id_ex_dst),
    .ex_mem_mem_read (ex_mem_mem_read),
    .ex_mem_dst      (ex_mem_dst),
    .hazard          (hazard)
  );

  always_comb begin
    dec    = decode(instr_q[31:26], instr_q[5:0], instr_q[25:21], instr_q[20:16], valid_q);
    ops_eq = (rs_data == rt_data);
    // A pending hazard means the compared operands are stale: never redirect on them.
    taken  = !hazard && ((dec.is_beq && ops_eq) || (dec.is_bne && !ops_eq) ||
                         dec.is_j || dec.is_jr);
    pc_src = PCSRC_PC4;
    if (taken) begin
      if (dec.is_jr)     pc_src = PCSRC_JR;
      else if (dec.is_j) pc_src = PCSRC_J;
      else               pc_src = PCSRC_BEQ;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pc_4_d  = pc_4_q;
    valid_d = valid_q;
    state_d = state_q;
    if (!hazard) begin
      pc_4_d = fetch.pc_4_if;
      if (taken && SQUASH_EN) begin
        instr_d = '0;
        valid_d = 1'b0;
      end else begin
        instr_d = fetch.instr_if;
        valid_d = 1'b1;
      end
    end
    unique case (state_q)
      ST_RUN: begin
        if (hazard)                  state_d = ST_STALL;
        else if (taken && SQUASH_EN) state_d = ST_SQUASH;
      end
      ST_STALL: if (!hazard) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_4_q  <= '0;
      valid_q <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      instr_q <= instr_d;
      pc_4_q  <= pc_4_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign instr_id       = instr_q;
  assign pc_4_id_full   = pc_4_q;
  assign id_valid       = valid_q;
  assign bubble_ex      = hazard || !valid_q;
  assign fetch.pc_write = rst_n && !hazard;
  assign fetch.pc_src   = pc_src;
  assign fetch.beq      = pc_4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign fetch.jr       = rst_n ? rs_data : 32'd0;
  assign fetch.offset28 = {instr_q[25:0], 2'b00};
  assign fetch.pc_4_id  = pc_4_q[31:28];

endmodule
